// File: rtl/pupil_det_pkg.sv
// Shared types for the pupil target detector: line-scan FSM states,
// default coordinate width and the bounding-box record.
package pupil_det_pkg;

  // Default width of every coordinate and count.
  localparam int CW_DEF = 12;

  // Per-line scan states: no ring, outer ring seen, inner run active,
  // closing ring seen after the run.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OUTER = 2'd1,
    ST_INNER = 2'd2,
    ST_CLOSE = 2'd3
  } line_state_t;

  // Bounding box record, sized for the default coordinate width.
  typedef struct packed {
    logic [CW_DEF-1:0] top;
    logic [CW_DEF-1:0] down;
    logic [CW_DEF-1:0] left;
    logic [CW_DEF-1:0] right;
  } box_t;

endpackage

// File: rtl/pupil_run_scan.sv
// Per-line run finder: walks green -> blue -> green along a line and flags
// enclosed blue runs whose length lies inside [run_min, run_max].
// The scan state lives in state_q for observation from the hierarchy.
module pupil_run_scan
  import pupil_det_pkg::*;
#(
  parameter int IMG_HDISP = 1280,
  parameter int PIX_W     = 8,
  parameter int CW        = CW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             pix_en,
  input  logic             roi_ok,
  input  logic [PIX_W-1:0] pix,
  input  logic [PIX_W-1:0] blue_min,
  input  logic [PIX_W-1:0] blue_max,
  input  logic [PIX_W-1:0] green_min,
  input  logic [PIX_W-1:0] green_max,
  input  logic [CW-1:0]    x,
  input  logic [CW-1:0]    ncnt,
  input  logic [CW-1:0]    run_min,
  input  logic [CW-1:0]    run_max,
  output logic             run_valid,
  output logic [CW-1:0]    run_left,
  output logic [CW-1:0]    run_right
);

  // Last two columns cannot close a run, so the scan is cut there.
  localparam logic [CW-1:0] X_EDGE = CW'(IMG_HDISP - 2);

  line_state_t   state_q, state_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [CW-1:0] left_q, left_d;
  logic [CW-1:0] right_q, right_d;
  logic          is_blue, is_green;
  logic          flag;
  logic [CW:0]   gap_inc;
  logic          gap_hit;
  logic [CW:0]   run_len;

  // Classification: blue wins where ranges overlap; outside the ROI neither.
  always_comb begin
    is_blue  = roi_ok && (pix >= blue_min) && (pix <= blue_max);
    is_green = roi_ok && !is_blue && (pix >= green_min) && (pix <= green_max);
  end

  // Next-state logic for the line FSM, gap counter and run edges.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    left_d  = left_q;
    right_d = right_q;
    flag    = 1'b0;
    gap_inc = {1'b0, gap_q} + (CW+1)'(1);
    gap_hit = (gap_inc >= {1'b0, ncnt});
    if (clr) begin
      state_d = ST_IDLE;
      gap_d   = '0;
    end else if (pix_en) begin
      case (state_q)
        ST_IDLE: begin
          gap_d = '0;
          if (is_green) state_d = ST_OUTER;
        end
        ST_OUTER: begin
          if (is_blue) begin
            state_d = ST_INNER;
            left_d  = x;
            gap_d   = '0;
          end else if (is_green) begin
            gap_d = '0;
          end else if (gap_hit) begin
            state_d = ST_IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_inc[CW-1:0];
          end
        end
        ST_INNER: begin
          if (is_green) begin
            state_d = ST_CLOSE;
            right_d = (x != '0) ? (x - CW'(1)) : '0;
            gap_d   = '0;
          end else if (is_blue) begin
            gap_d = '0;
          end else if (gap_hit) begin
            state_d = ST_IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_inc[CW-1:0];
          end
        end
        ST_CLOSE: begin
          // One pixel after the closing green, whatever it is, ends the run.
          flag    = 1'b1;
          state_d = ST_IDLE;
          gap_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end
      endcase
      // An INNER run reaching the line edge is dropped: it has no closing ring.
      if (x >= X_EDGE) begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    end
  end

  // Run length check on the latched edges.
  always_comb begin
    run_len   = (right_q >= left_q) ? ({1'b0, right_q} - {1'b0, left_q} + (CW+1)'(1)) : '0;
    run_valid = flag && (run_len >= {1'b0, run_min}) && (run_len <= {1'b0, run_max});
    run_left  = left_q;
    run_right = right_q;
  end

  // State register for the line FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

endmodule

// File: rtl/pupil_target_det.sv
// Pupil target detector: finds a blue disc ringed by green, grows a box over
// vertically adjacent runs and reports it once per frame on vsync rise.
// Optional feature macro PUPIL_ROI_EN restricts the search to a square ROI.
module pupil_target_det
  import pupil_det_pkg::*;
#(
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720,
  parameter int PIX_W     = 8,
  parameter int CW        = CW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic [PIX_W-1:0] per_img_Bit,
  input  logic [PIX_W-1:0] Blue_min,
  input  logic [PIX_W-1:0] Blue_max,
  input  logic [PIX_W-1:0] Green_min,
  input  logic [PIX_W-1:0] Green_max,
  input  logic [CW-1:0]    NCNT,
  input  logic [CW-1:0]    deh,
  input  logic [CW-1:0]    run_min,
  input  logic [CW-1:0]    run_max,
  input  logic [CW-1:0]    box_min,
  input  logic [CW-1:0]    box_max,
`ifdef PUPIL_ROI_EN
  input  logic [2*CW-1:0]  roi_center,
  input  logic [CW-1:0]    roi_half,
`endif
  output logic             det_valid,
  output logic             det_found,
  output logic [CW-1:0]    center_x,
  output logic [CW-1:0]    center_y,
  output logic [CW-1:0]    out_top,
  output logic [CW-1:0]    out_down,
  output logic [CW-1:0]    out_left,
  output logic [CW-1:0]    out_right
);

  localparam logic [CW-1:0] X_LAST = CW'(IMG_HDISP - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(IMG_VDISP - 1);

  logic          vsync_q;
  logic          vs_rise;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          roi_ok;
  logic          run_valid;
  logic [CW-1:0] run_left, run_right;

  box_t          region_q, region_d;
  logic          reg_vld_q, reg_vld_d;
  logic [CW-1:0] prev_l_q, prev_l_d, prev_r_q, prev_r_d;
  logic [CW-1:0] last_y_q, last_y_d;
  logic [CW-1:0] dy_run;
  logic          overlap, join_run;

  logic          dv_q, dv_d, found_q, found_d;
  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
  box_t          box_q, box_d;
  logic [CW:0]   box_w, box_h, sum_x, sum_y;
  logic          found_now;

  assign vs_rise = per_frame_vsync && !vsync_q;

  // Pixel position: advances per clken, wraps per line, restarts on vsync.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (vs_rise) begin
      x_d = '0;
      y_d = '0;
    end else if (per_frame_clken) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : (y_q + CW'(1));
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

`ifdef PUPIL_ROI_EN
  logic [CW-1:0] roi_cx, roi_cy, roi_dx, roi_dy;
  // Square window around the ROI centre; distances taken without underflow.
  always_comb begin
    roi_cx = roi_center[CW-1:0];
    roi_cy = roi_center[2*CW-1:CW];
    roi_dx = (x_q >= roi_cx) ? (x_q - roi_cx) : (roi_cx - x_q);
    roi_dy = (y_q >= roi_cy) ? (y_q - roi_cy) : (roi_cy - y_q);
    roi_ok = (roi_dx <= roi_half) && (roi_dy <= roi_half);
  end
`else
  assign roi_ok = 1'b1;
`endif

  pupil_run_scan #(
    .IMG_HDISP (IMG_HDISP),
    .PIX_W     (PIX_W),
    .CW        (CW)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (vs_rise),
    .pix_en    (per_frame_clken && per_frame_href),
    .roi_ok    (roi_ok),
    .pix       (per_img_Bit),
    .blue_min  (Blue_min),
    .blue_max  (Blue_max),
    .green_min (Green_min),
    .green_max (Green_max),
    .x         (x_q),
    .ncnt      (NCNT),
    .run_min   (run_min),
    .run_max   (run_max),
    .run_valid (run_valid),
    .run_left  (run_left),
    .run_right (run_right)
  );

  // Region growth: the first accepted run seeds it, later runs must overlap
  // the last joined run and stay within deh lines of it.
  always_comb begin
    region_d = region_q;
    reg_vld_d = reg_vld_q;
    prev_l_d = prev_l_q;
    prev_r_d = prev_r_q;
    last_y_d = last_y_q;
    dy_run   = (y_q >= last_y_q) ? (y_q - last_y_q) : '1;
    overlap  = (run_left <= prev_r_q) && (run_right >= prev_l_q);
    join_run = run_valid && (!reg_vld_q || (overlap && (dy_run <= deh)));
    if (vs_rise) begin
      region_d  = '0;
      reg_vld_d = 1'b0;
      prev_l_d  = '0;
      prev_r_d  = '0;
      last_y_d  = '0;
    end else if (join_run) begin
      reg_vld_d = 1'b1;
      prev_l_d  = run_left;
      prev_r_d  = run_right;
      last_y_d  = y_q;
      region_d.down = y_q;
      if (!reg_vld_q) begin
        region_d.top   = y_q;
        region_d.left  = run_left;
        region_d.right = run_right;
      end else begin
        region_d.left  = (run_left < region_q.left) ? run_left : region_q.left;
        region_d.right = (run_right > region_q.right) ? run_right : region_q.right;
      end
    end
  end

  // Frame evaluation: size-check the region and latch the result on vsync rise.
  always_comb begin
    box_w = (region_q.right >= region_q.left) ?
            ({1'b0, region_q.right} - {1'b0, region_q.left} + (CW+1)'(1)) : '0;
    box_h = (region_q.down >= region_q.top) ?
            ({1'b0, region_q.down} - {1'b0, region_q.top} + (CW+1)'(1)) : '0;
    sum_x = {1'b0, region_q.left} + {1'b0, region_q.right};
    sum_y = {1'b0, region_q.top} + {1'b0, region_q.down};
    found_now = reg_vld_q &&
                (box_w >= {1'b0, box_min}) && (box_w <= {1'b0, box_max}) &&
                (box_h >= {1'b0, box_min}) && (box_h <= {1'b0, box_max});
    dv_d    = vs_rise;
    found_d = found_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    box_d   = box_q;
    if (vs_rise) begin
      found_d = found_now;
      cx_d    = found_now ? sum_x[CW:1] : '0;
      cy_d    = found_now ? sum_y[CW:1] : '0;
      box_d   = found_now ? region_q : '0;
    end
  end

  // All state registers; reset clears position, region and every output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      region_q  <= '0;
      reg_vld_q <= 1'b0;
      prev_l_q  <= '0;
      prev_r_q  <= '0;
      last_y_q  <= '0;
      dv_q      <= 1'b0;
      found_q   <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      box_q     <= '0;
    end else begin
      vsync_q   <= per_frame_vsync;
      x_q       <= x_d;
      y_q       <= y_d;
      region_q  <= region_d;
      reg_vld_q <= reg_vld_d;
      prev_l_q  <= prev_l_d;
      prev_r_q  <= prev_r_d;
      last_y_q  <= last_y_d;
      dv_q      <= dv_d;
      found_q   <= found_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      box_q     <= box_d;
    end
  end

  assign det_valid = dv_q;
  assign det_found = found_q;
  assign center_x  = cx_q;
  assign center_y  = cy_q;
  assign out_top   = box_q.top;
  assign out_down  = box_q.down;
  assign out_left  = box_q.left;
  assign out_right = box_q.right;

endmodule
